// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types: frame FSM states, prefix codes, parity helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
    localparam int         PS2_DATA_BITS  = 8;

    // Decoded key event as held on the outputs
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_evt_t;

    // Odd parity: data bits plus parity bit must contain an odd number of ones
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronises ps2clk/ps2data, de-glitches ps2clk and emits a falling-edge strobe.
// Latency: fall strobe SYNC_STAGES+FILTER_LEN-1 cycles after the first capturing edge of a pin change.
// Backpressure: none; fall is a free-running 1-cycle strobe.
`timescale 1ns/1ps
module ps2_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_raw,
    input  logic data_raw,
    output logic data_sync,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_s;
    logic                   clk_filt;
    logic [CW-1:0]          stab_cnt;

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign data_sync = data_sync_q[SYNC_STAGES-1];

    // Metastability synchronisers; idle-high lines reset to 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync    <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync    <= {clk_sync[SYNC_STAGES-2:0], clk_raw};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data_raw};
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN stable cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_filt <= 1'b1;
            stab_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s != clk_filt) begin
                if (stab_cnt == CW'(FILTER_LEN - 1)) begin
                    clk_filt <= clk_s;
                    stab_cnt <= '0;
                    fall     <= ~clk_s;
                end else begin
                    stab_cnt <= stab_cnt + 1'b1;
                end
            end else begin
                stab_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: 11-bit frames folded with E0/F0 prefixes into key events; PS2_TIMEOUT_EN adds a frame timeout.
// Latency: strobe SYNC_STAGES+FILTER_LEN+1 cycles after the stop-bit falling edge on the ps2clk pin.
// Backpressure: none; key_valid/parity_err/frame_err are 1-cycle strobes the consumer must take.
`timescale 1ns/1ps
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8
`ifdef PS2_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 100000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       parity_err,
    output logic       frame_err
);

    ps2_state_t state, state_nxt;
    logic       fall;
    logic       data_s;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic       par_ok;
    logic       ext_pend, brk_pend;
    logic       to_hit;
    logic       ev_key, ev_par, ev_frame, set_ext, set_brk;
    key_evt_t   key_q;

    assign key_code  = key_q.code;
    assign key_ext   = key_q.ext;
    assign key_break = key_q.brk;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync_filter (
        .clk       (clk),
        .reset     (reset),
        .clk_raw   (ps2clk),
        .data_raw  (ps2data),
        .data_sync (data_s),
        .fall      (fall)
    );

`ifdef PS2_TIMEOUT_EN
    logic [16:0] to_cnt;

    // Inter-edge watchdog: cleared by every fall, runs only inside a frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (fall || state == IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_hit = (state != IDLE) && !fall && (to_cnt == 17'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: advances on filtered ps2clk falls; timeout aborts to IDLE
    always_comb begin
        state_nxt = state;
        if (to_hit) begin
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_s) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stop-bit verdict: first matching condition wins, errors take precedence over prefixes
    always_comb begin
        ev_key   = 1'b0;
        ev_par   = 1'b0;
        ev_frame = 1'b0;
        set_ext  = 1'b0;
        set_brk  = 1'b0;
        if (to_hit) begin
            ev_frame = 1'b1;
        end else if (fall && state == STOP) begin
            if (!data_s)                  ev_frame = 1'b1;
            else if (!par_ok)             ev_par   = 1'b1;
            else if (sr == PS2_EXT_PREFIX) set_ext  = 1'b1;
            else if (sr == PS2_BRK_PREFIX) set_brk  = 1'b1;
            else                          ev_key   = 1'b1;
        end
    end

    // Deserialiser: LSB-first right shift, bit counter and parity capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr      <= '0;
            bit_cnt <= '0;
            par_ok  <= 1'b0;
        end else if (fall) begin
            case (state)
                IDLE:    bit_cnt <= '0;
                DATA: begin
                    sr      <= {data_s, sr[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                PARITY:  par_ok <= odd_parity_ok({sr, data_s});
                default: ;
            endcase
        end
    end

    // Event outputs and prefix flags; any emitted strobe consumes the pending prefixes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            key_q      <= '0;
            key_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            key_valid  <= ev_key;
            parity_err <= ev_par;
            frame_err  <= ev_frame;
            if (ev_key || ev_par || ev_frame) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else begin
                if (set_ext) ext_pend <= 1'b1;
                if (set_brk) brk_pend <= 1'b1;
            end
            if (ev_key) begin
                key_q.code <= sr;
                key_q.ext  <= ext_pend;
                key_q.brk  <= brk_pend;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: drives PS/2 frames on the pins, checks every strobe against a queue.
// Latency: checks pin-to-strobe delay and, with PS2_TIMEOUT_EN, the timeout delay.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_ps2_rx_frame;

    localparam int SYNC   = 2;
    localparam int FILT   = 8;
    localparam int TO     = 2000;
    localparam int HALF   = 40;     // clk cycles per PS/2 clock half period
    localparam int LAT    = SYNC + FILT + 1;
    localparam int EV_KEY = 1;
    localparam int EV_PAR = 2;
    localparam int EV_FRM = 3;

    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic [7:0] key_code;
    logic       key_ext, key_break, key_valid, parity_err, frame_err;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   t_fall = 0;
    int   evt_cyc = 0;
    int   t_last;
    int   mon_kind;
    exp_t mon_e;
    exp_t sb[$];
    logic [7:0] hold_code = 8'h00;
    logic       hold_ext = 1'b0;
    logic       hold_brk = 1'b0;

    ps2_rx_frame #(
        .SYNC_STAGES    (SYNC),
        .FILTER_LEN     (FILT)
`ifdef PS2_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2clk     (ps2clk),
        .ps2data    (ps2data),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_break  (key_break),
        .key_valid  (key_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int kind, input logic [7:0] code, input logic ext, input logic brk);
        exp_t e;
        e.kind = kind;
        e.code = code;
        e.ext  = ext;
        e.brk  = brk;
        sb.push_back(e);
    endtask

    // Bit i of an 11-bit frame: start, 8 data LSB first, odd parity, stop
    function automatic logic bit_of(input logic [7:0] code, input logic par_bad,
                                    input logic stop_bad, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return code[i-1];
        if (i == 9) return (~^code) ^ par_bad;
        return ~stop_bad;
    endfunction

    task automatic send_range(input logic [7:0] code, input logic par_bad, input logic stop_bad,
                              input int glitch_at, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            ps2data = bit_of(code, par_bad, stop_bad, i);
            if (i == glitch_at) begin
                repeat (10) @(negedge clk);
                ps2clk = 1'b0;
                repeat (3) @(negedge clk);
                ps2clk = 1'b1;
                repeat (HALF - 13) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2clk = 1'b0;
            t_fall = cyc;
            repeat (HALF) @(negedge clk);
            ps2clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] code, input logic par_bad, input logic stop_bad,
                              input int glitch_at);
        send_range(code, par_bad, stop_bad, glitch_at, 0, 10);
        @(negedge clk);
        ps2data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check_eq(tag, sb.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_code"},  key_code,   8'h00);
        check_eq({tag, "_ext"},   key_ext,    1'b0);
        check_eq({tag, "_brk"},   key_break,  1'b0);
        check_eq({tag, "_valid"}, key_valid,  1'b0);
        check_eq({tag, "_perr"},  parity_err, 1'b0);
        check_eq({tag, "_ferr"},  frame_err,  1'b0);
    endtask

    // Scoreboard consumer: every strobe pops one expectation
    always @(negedge clk) begin
        if (reset && (key_valid || parity_err || frame_err)) begin
            mon_kind = key_valid ? EV_KEY : (parity_err ? EV_PAR : EV_FRM);
            evt_cyc  = cyc;
            check_eq("strobe_onehot", 32'(key_valid) + 32'(parity_err) + 32'(frame_err), 1);
            if (sb.size() == 0) begin
                check_eq("unexpected_evt", mon_kind, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("evt_kind", mon_kind, mon_e.kind);
                if (mon_e.kind == EV_KEY) begin
                    hold_code = mon_e.code;
                    hold_ext  = mon_e.ext;
                    hold_brk  = mon_e.brk;
                end
                check_eq("key_code", key_code, hold_code);
                check_eq("key_ext", key_ext, hold_ext);
                check_eq("key_break", key_break, hold_brk);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Single make code, plus pin-to-strobe latency
        push_exp(EV_KEY, 8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        wait_drain("drain_t1", 200);
        check_eq("lat_key", evt_cyc - t_fall, LAT);

        // Break and extended-break sequences
        push_exp(EV_KEY, 8'h1C, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b0, -1);
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        push_exp(EV_KEY, 8'h75, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b0, -1);
        send_frame(8'hF0, 1'b0, 1'b0, -1);
        send_frame(8'h75, 1'b0, 1'b0, -1);
        wait_drain("drain_t2", 200);

        // Repeated prefixes collapse into one flag each
        push_exp(EV_KEY, 8'h74, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b0, -1);
        send_frame(8'hE0, 1'b0, 1'b0, -1);
        send_frame(8'hF0, 1'b0, 1'b0, -1);
        send_frame(8'hF0, 1'b0, 1'b0, -1);
        send_frame(8'h74, 1'b0, 1'b0, -1);
        wait_drain("drain_idem", 200);

        // Parity error, stop-bit error, then recovery with no stale break flag
        push_exp(EV_PAR, 8'h00, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0, -1);
        push_exp(EV_FRM, 8'h00, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        push_exp(EV_KEY, 8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        wait_drain("drain_t3", 200);

        // Short ps2clk glitches while idle (data low) and mid-frame must be ignored
        @(negedge clk);
        ps2data = 1'b0;
        ps2clk  = 1'b0;
        repeat (3) @(negedge clk);
        ps2clk  = 1'b1;
        repeat (20) @(negedge clk);
        ps2data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        push_exp(EV_KEY, 8'h2B, 1'b0, 1'b0);
        send_frame(8'h2B, 1'b0, 1'b0, 3);
        wait_drain("drain_t4", 200);

`ifdef PS2_TIMEOUT_EN
        // Stalled frame times out exactly TIMEOUT_CYCLES after its last fall
        push_exp(EV_FRM, 8'h00, 1'b0, 1'b0);
        send_range(8'h1C, 1'b0, 1'b0, -1, 0, 4);
        t_last = t_fall;
        @(negedge clk);
        ps2data = 1'b1;
        wait_drain("drain_timeout", TO + 200);
        check_eq("lat_timeout", evt_cyc - t_last, LAT + TO);
        push_exp(EV_KEY, 8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        wait_drain("drain_t5", 200);
`else
        // Without the timeout a stalled frame simply resumes
        push_exp(EV_KEY, 8'h1C, 1'b0, 1'b0);
        send_range(8'h1C, 1'b0, 1'b0, -1, 0, 4);
        repeat (TO + 200) @(negedge clk);
        check_eq("stall_no_evt", sb.size(), 1);
        send_range(8'h1C, 1'b0, 1'b0, -1, 5, 10);
        @(negedge clk);
        ps2data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        wait_drain("drain_t5", 200);
`endif

        // Async reset mid-frame after a break prefix
        send_frame(8'hF0, 1'b0, 1'b0, -1);
        send_range(8'h1C, 1'b0, 1'b0, -1, 0, 3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("midreset");
        hold_code = 8'h00;
        hold_ext  = 1'b0;
        hold_brk  = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        ps2data = 1'b1;
        repeat (100) @(negedge clk);
        push_exp(EV_KEY, 8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        wait_drain("drain_t6", 200);

        repeat (200) @(negedge clk);
        check_eq("sb_final", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
